cash_ctrl: RTL and testbench
============================

// Module: cash_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate controller sitting upstream of the cache data array
//  (128 words, 4-word lines, negedge write). Holds tag/valid arrays, decides hit/miss, stalls the CPU,
//  fetches 128-bit lines from main memory and drives the array's we/read_miss/data_in for line fill or word update.
// PARAMETERS
//  length  128  cache words; lines = length/4; index = addr[$clog2(length)-1:2], tag = addr[width-1:$clog2(length)]
//  width   32   word/address width; line = 4*width
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst_n       in   1        synchronous active-low reset (sampled on posedge clk)
//  cpu_rd      in   1        CPU load request
//  cpu_wr      in   1        CPU store request (wins if both asserted)
//  cpu_addr    in   width    word address
//  cpu_wdata   in   width    store data
//  stall       out  1        hold CPU (combinational)
//  we          out  1        data array write enable
//  read_miss   out  1        1 = 4-word line fill, 0 = single-word write
//  data_in     out  4*width  data array write data
//  mem_rd      out  1        main memory line read request
//  mem_wr      out  1        main memory word write request
//  mem_addr    out  width    memory address (line-aligned for reads)
//  mem_wdata   out  width    memory write data
//  mem_rdata   in   4*width  line from memory, word k at [(k+1)*width-1:k*width]
//  mem_ready   in   1        memory done; one-cycle pulse, valid only while mem_rd/mem_wr high
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits 0, req_addr/req_data/line_buf 0; stall, we, read_miss, mem_rd, mem_wr = 0;
//   data_in, mem_addr, mem_wdata = 0. Reset mid-operation aborts the request; no array write, valid stays cleared.
//  hit = valid[idx] && tag_arr[idx]==tag, evaluated on cpu_addr in IDLE, on req_addr otherwise.
//  States:
//   IDLE : cpu_wr -> stall=1, latch addr/data, -> WRITE. cpu_rd & hit -> stall=0, stay (0-cycle hit).
//          cpu_rd & miss -> stall=1, latch addr, -> FETCH. No request -> stall=0. mem_ready ignored.
//   FETCH: stall=1, mem_rd=1, mem_addr={req_addr[width-1:2],2'b00}. Hold until mem_ready; on mem_ready:
//          line_buf<=mem_rdata, tag_arr[idx]<=tag, valid[idx]<=1, -> FILL.
//   FILL : stall=1, we=1, read_miss=1, data_in=line_buf (array writes on the negedge of this cycle); -> IDLE.
//          Next cycle the IDLE re-evaluation hits; read miss = 3 + memory latency cycles.
//   WRITE: mem_wr=1, mem_addr=req_addr, mem_wdata=req_data; stall=1 until mem_ready.
//          On the mem_ready cycle: stall=0; if hit, we=1, read_miss=0, data_in={3*width'0, req_data}; -> IDLE.
//          Miss: memory only, tags untouched (no allocate).
//  Memory requests are held stable until mem_ready; one outstanding request at most.
//  Outputs we/read_miss/mem_* are 0 in states that do not drive them; data_in=0 when we=0.
//  Conflict: same index, different tag -> miss; fill overwrites tag, no writeback (write-through).
// TESTING
//  Cold read 0x40, mem_ready after 2 cycles, line {D3,D2,D1,D0} -> stall for 5 cycles, one FILL pulse
//   (we=1, read_miss=1), mem_addr=0x40, valid[16]=1.
//  Then read 0x41, 0x42, 0x43 -> stall=0 every cycle, mem_rd never asserted.
//  Write hit 0x42 data 0xDEADBEEF, mem_ready after 1 cycle -> mem_wr with addr 0x42; we=1, read_miss=0,
//   data_in[31:0]=0xDEADBEEF on the ready cycle; following read 0x42 hits.
//  Write miss 0x200 -> mem_wr only, we never 1, a subsequent read of 0x200 misses.
//  Conflict: after the 0x40 fill, read 0xC0 (index 16) -> miss, fetch 0xC0, tag replaced; re-read 0x40 -> miss.
//  Assert rst_n=0 while in FETCH -> next cycle: IDLE, stall=0, mem_rd=0, all valid=0; read 0x40 misses.

Source files
------------

// File: rtl/cash_ctrl.sv
// cash_ctrl: direct-mapped write-through no-write-allocate cache controller
// driving tag/valid state, CPU stall, line fills from memory and word updates to the data array.
module cash_ctrl #(
    parameter int length = 128,
    parameter int width  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [width-1:0]     cpu_addr,
    input  logic [width-1:0]     cpu_wdata,
    output logic                 stall,
    output logic                 we,
    output logic                 read_miss,
    output logic [4*width-1:0]   data_in,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [width-1:0]     mem_addr,
    output logic [width-1:0]     mem_wdata,
    input  logic [4*width-1:0]   mem_rdata,
    input  logic                 mem_ready
);
    localparam int lines = length / 4;
    localparam int ob    = $clog2(length);
    localparam int iw    = ob - 2;
    localparam int tw    = width - ob;

    typedef enum logic [1:0] {IDLE, FETCH, FILL, WRITE} state_t;

    state_t             state, state_nx;
    logic [lines-1:0]   valid;
    logic [tw-1:0]      tag_arr [lines];
    logic [width-1:0]   req_addr, req_data;
    logic [4*width-1:0] line_buf;
    logic [iw-1:0]      idx;
    logic [tw-1:0]      tag;
    logic               hit;

    // Lookup uses the live CPU address while idle, the latched request otherwise
    always_comb begin
        idx = (state == IDLE) ? cpu_addr[ob-1:2] : req_addr[ob-1:2];
        tag = (state == IDLE) ? cpu_addr[width-1:ob] : req_addr[width-1:ob];
        hit = valid[idx] && tag_arr[idx] == tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= '0;
            req_addr <= '0;
            req_data <= '0;
            line_buf <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cpu_wr) begin
                req_addr <= cpu_addr;
                req_data <= cpu_wdata;
            end else if (state == IDLE && cpu_rd && !hit) begin
                req_addr <= cpu_addr;
            end
            if (state == FETCH && mem_ready) begin
                line_buf   <= mem_rdata;
                valid[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state == FETCH && mem_ready) tag_arr[idx] <= tag;
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        we        = 1'b0;
        read_miss = 1'b0;
        data_in   = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                stall    = cpu_wr || (cpu_rd && !hit);
                state_nx = cpu_wr ? WRITE : (cpu_rd && !hit) ? FETCH : IDLE;
            end
            FETCH: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {req_addr[width-1:2], 2'b00};
                state_nx = mem_ready ? FILL : FETCH;
            end
            FILL: begin
                stall     = 1'b1;
                we        = 1'b1;
                read_miss = 1'b1;
                data_in   = line_buf;
                state_nx  = IDLE;
            end
            WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = req_data;
                stall     = !mem_ready;
                we        = mem_ready && hit;
                data_in   = (mem_ready && hit) ? {{(3*width){1'b0}}, req_data} : '0;
                state_nx  = mem_ready ? IDLE : WRITE;
            end
            default: state_nx = IDLE;
        endcase
        // Hold every output quiet while reset is asserted
        if (!rst_n) begin
            stall     = 1'b0;
            we        = 1'b0;
            read_miss = 1'b0;
            data_in   = '0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end
endmodule

// File: tb/tb_cash_ctrl.sv
// tb_cash_ctrl: cycle-by-cycle directed vectors for cash_ctrl with hand-computed outputs.
module tb_cash_ctrl;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0]   cpu_addr = '0, cpu_wdata = '0;
    logic          stall, we, read_miss, mem_rd, mem_wr;
    logic [127:0]  data_in, mem_rdata = '0;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_ready = 1'b0;

    int total = 0;
    int bad = 0;

    cash_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .stall(stall), .we(we),
        .read_miss(read_miss), .data_in(data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd, wr;
        logic [31:0]  addr, wdata;
        logic         rdy;
        int           ln;
        logic [196:0] exp;
    } vec_t;

    vec_t         tab[$];
    logic [127:0] lines [3];

    function automatic logic [196:0] pk(input logic st, w, rm, mrd, mwr,
                                        input logic [31:0] ma, mwd, input logic [127:0] din);
        return {st, w, rm, mrd, mwr, ma, mwd, din};
    endfunction

    task automatic add(input logic rd, wr, input logic [31:0] a, wd, input logic rdy,
                       input int ln, input logic [196:0] e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.rdy = rdy; v.ln = ln; v.exp = e;
        tab.push_back(v);
    endtask

    task automatic step(input logic rn, rd, wr, input logic [31:0] a, wd, input logic rdy,
                        input logic [127:0] rdat, input logic [196:0] e, input string nm);
        logic [196:0] got;
        @(negedge clk);
        rst_n = rn; cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
        mem_ready = rdy; mem_rdata = rdat;
        #2;
        got = {stall, we, read_miss, mem_rd, mem_wr, mem_addr, mem_wdata, data_in};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, e);
        end
    endtask

    logic [196:0] z;

    initial begin
        lines[0] = 128'h13131313_12121212_11111111_10101010;
        lines[1] = 128'h23232323_22222222_21212121_20202020;
        lines[2] = 128'h33333333_32323232_31313131_30303030;
        z = '0;
        // cold read 0x40: miss, two waiting FETCH cycles, ready, FILL, then hit
        add(1, 0, 'h40, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 'h40, 0, 0, 0, pk(1, 0, 0, 1, 0, 'h40, 0, 0));
        add(1, 0, 'h40, 0, 0, 0, pk(1, 0, 0, 1, 0, 'h40, 0, 0));
        add(1, 0, 'h40, 0, 1, 0, pk(1, 0, 0, 1, 0, 'h40, 0, 0));
        add(1, 0, 'h40, 0, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, lines[0]));
        add(1, 0, 'h40, 0, 0, 0, z);
        add(1, 0, 'h41, 0, 0, 0, z);
        add(1, 0, 'h42, 0, 0, 0, z);
        add(1, 0, 'h43, 0, 0, 0, z);
        // write hit 0x42
        add(0, 1, 'h42, 'hDEADBEEF, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 'h42, 'hDEADBEEF, 0, 0, pk(1, 0, 0, 0, 1, 'h42, 'hDEADBEEF, 0));
        add(0, 1, 'h42, 'hDEADBEEF, 1, 0, pk(0, 1, 0, 0, 1, 'h42, 'hDEADBEEF, {96'h0, 32'hDEADBEEF}));
        add(1, 0, 'h42, 0, 0, 0, z);
        // write miss 0x200: memory only, then the read misses
        add(0, 1, 'h200, 'h12345678, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(0, 1, 'h200, 'h12345678, 1, 0, pk(0, 0, 0, 0, 1, 'h200, 'h12345678, 0));
        add(1, 0, 'h200, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 'h200, 0, 1, 1, pk(1, 0, 0, 1, 0, 'h200, 0, 0));
        add(1, 0, 'h200, 0, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, lines[1]));
        add(1, 0, 'h200, 0, 0, 0, z);
        // conflict on index 16: 0xC0 evicts 0x40
        add(1, 0, 'hC0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 'hC0, 0, 1, 2, pk(1, 0, 0, 1, 0, 'hC0, 0, 0));
        add(1, 0, 'hC0, 0, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, lines[2]));
        add(1, 0, 'hC0, 0, 0, 0, z);
        add(1, 0, 'h40, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 0, 'h40, 0, 1, 0, pk(1, 0, 0, 1, 0, 'h40, 0, 0));
        add(1, 0, 'h40, 0, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, lines[0]));
        add(1, 0, 'h40, 0, 0, 0, z);
        // simultaneous rd/wr: write wins; stray mem_ready in IDLE is ignored
        add(1, 1, 'h41, 'h55, 0, 0, pk(1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 1, 'h41, 'h55, 1, 0, pk(0, 1, 0, 0, 1, 'h41, 'h55, {96'h0, 32'h55}));
        add(1, 0, 'h41, 0, 1, 0, z);
        add(1, 0, 'h43, 0, 0, 0, z);

        // outputs held at zero during reset even with a request pending
        step(0, 1, 0, 'h40, 0, 0, '0, z, "reset_hold");
        step(0, 1, 0, 'h40, 0, 0, '0, z, "reset_state");
        foreach (tab[i])
            step(1, tab[i].rd, tab[i].wr, tab[i].addr, tab[i].wdata, tab[i].rdy,
                 lines[tab[i].ln], tab[i].exp, $sformatf("vec%0d", i));

        // reset while in FETCH aborts and clears all valid bits
        step(1, 1, 0, 'h44, 0, 0, '0, pk(1, 0, 0, 0, 0, 0, 0, 0), "rst_miss");
        step(1, 1, 0, 'h44, 0, 0, '0, pk(1, 0, 0, 1, 0, 'h44, 0, 0), "rst_fetch");
        step(0, 1, 0, 'h44, 0, 1, lines[1], z, "rst_assert");
        step(1, 0, 0, 'h0, 0, 0, '0, z, "rst_idle");
        step(1, 1, 0, 'h40, 0, 0, '0, pk(1, 0, 0, 0, 0, 0, 0, 0), "rst_cold40");
        step(1, 1, 0, 'h40, 0, 0, '0, pk(1, 0, 0, 1, 0, 'h40, 0, 0), "rst_fetch40");
        step(1, 1, 0, 'h40, 0, 1, lines[0], pk(1, 0, 0, 1, 0, 'h40, 0, 0), "rst_ready40");
        step(1, 1, 0, 'h40, 0, 0, '0, pk(1, 1, 1, 0, 0, 0, 0, lines[0]), "rst_fill40");
        step(1, 1, 0, 'h40, 0, 0, '0, z, "rst_hit40");
        step(1, 1, 0, 'hC0, 0, 0, '0, pk(1, 0, 0, 0, 0, 0, 0, 0), "rst_c0_miss");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
